// File: rtl/chess_pkg.sv
// Shared definitions for the per-square move serializer: packed move-word field
// offsets, castling and colour constants, and the serializer state encoding.
package chess_pkg;

  // Field offsets inside a packed move word
  localparam int TO_LSB       = 0;
  localparam int TO_W         = 6;
  localparam int FLAGS_LSB    = 6;
  localparam int FLAGS_W      = 6;
  localparam int FROM_LSB     = 12;
  localparam int FROM_W       = 6;
  localparam int CAPTURED_LSB = 18;
  localparam int CAPTURED_W   = 6;
  localparam int CASTLING_LSB = 24;
  localparam int CASTLING_W   = 4;

  // Value presented on the move output when nothing is pending
  localparam logic [31:0] EMPTY_MOVE_OUT = 32'h0000_0000;

  // Castling right bits
  localparam logic [3:0] WHITE_KINGS_SIDE  = 4'b0001;
  localparam logic [3:0] WHITE_QUEENS_SIDE = 4'b0010;
  localparam logic [3:0] BLACK_KINGS_SIDE  = 4'b0100;
  localparam logic [3:0] BLACK_QUEENS_SIDE = 4'b1000;

  // Side to move
  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  // Serializer states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/square_move_serializer_if.sv
// Output stream of the move serializer: one move word plus its direction index,
// transferred on out_valid && out_ready.
interface square_move_serializer_if #(
  parameter int MOVE_W  = 32,
  parameter int NUM_DIR = 16
);
  logic                       out_valid;
  logic                       out_ready;
  logic [MOVE_W-1:0]          out_move;
  logic [$clog2(NUM_DIR)-1:0] out_idx;

  // Serializer side drives the move, collector side drives ready
  modport master (output out_valid, output out_move, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_move, input out_idx, output out_ready);
endinterface

// File: rtl/square_move_serializer_find_first.sv
// Combinational lowest-set-bit encoder used to pick the next pending direction.
module find_first #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  output logic                 found,
  output logic [$clog2(N)-1:0] index
);

  // Scan from the top down so the lowest set bit wins
  always_comb begin
    found = |req;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = ($clog2(N))'(i);
    end
  end

endmodule

// File: rtl/square_move_serializer.sv
// Per-square move serializer: latches NUM_DIR packed move words on start and
// streams the non-empty ones over a valid/ready handshake, lowest index first.
// Optional feature macro: CAPTURE_FIRST_EN -- captures stream before quiet moves.
module square_move_serializer
  import chess_pkg::*;
#(
  parameter int MOVE_W  = 32,
  parameter int NUM_DIR = 16,
  parameter int CAP_LSB = 18,
  parameter int CAP_W   = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_DIR*MOVE_W-1:0]    moves_in,
  square_move_serializer_if.master     out_if,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_DIR+1)-1:0] move_count
);

  localparam int IDX_W = $clog2(NUM_DIR);
  localparam int CNT_W = $clog2(NUM_DIR + 1);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SCAN = SCAN;

  logic [0:0]         state_reg;
  logic [MOVE_W-1:0]  buffer_reg [NUM_DIR];
  logic [CNT_W-1:0]   count_reg;
  logic               done_reg;

  logic [NUM_DIR-1:0] word_nz;
  logic [NUM_DIR-1:0] word_cap;
  logic [NUM_DIR-1:0] sel_onehot;
  logic [IDX_W-1:0]   sel;
  logic               any_pending;
  logic               pending_empty_next;
  logic               scan_active;
  logic               load_en;
  logic               xfer;

  // Classify each incoming word: non-empty, and whether it captures a piece
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIR; gi++) begin : g_classify
      assign word_nz[gi]  = |moves_in[gi*MOVE_W +: MOVE_W];
      assign word_cap[gi] = |moves_in[gi*MOVE_W + CAP_LSB +: CAP_W];
    end
  endgenerate

  assign scan_active = (state_reg == ST_SCAN);
  // abort outranks start, so a start in the same cycle as abort is dropped
  assign load_en     = !abort && (state_reg == ST_IDLE) && start;
  assign xfer        = out_if.out_valid && out_if.out_ready;
  assign sel_onehot  = {{(NUM_DIR-1){1'b0}}, 1'b1} << sel;

`ifdef CAPTURE_FIRST_EN
  logic [NUM_DIR-1:0] cap_pend_reg;
  logic [NUM_DIR-1:0] cap_pend_next;
  logic [NUM_DIR-1:0] quiet_pend_reg;
  logic [NUM_DIR-1:0] quiet_pend_next;
  logic               cap_found;
  logic               quiet_found;
  logic [IDX_W-1:0]   cap_idx;
  logic [IDX_W-1:0]   quiet_idx;

  find_first #(.N(NUM_DIR)) u_ff_cap (
    .req   (cap_pend_reg),
    .found (cap_found),
    .index (cap_idx)
  );

  find_first #(.N(NUM_DIR)) u_ff_quiet (
    .req   (quiet_pend_reg),
    .found (quiet_found),
    .index (quiet_idx)
  );

  // Captures drain completely before any quiet move is offered
  assign any_pending = cap_found | quiet_found;
  assign sel         = cap_found ? cap_idx : quiet_idx;

  // Remove the transferred move from whichever mask it came from
  always_comb begin
    cap_pend_next   = cap_pend_reg;
    quiet_pend_next = quiet_pend_reg;
    if (xfer) begin
      if (cap_found) cap_pend_next   = cap_pend_reg & ~sel_onehot;
      else           quiet_pend_next = quiet_pend_reg & ~sel_onehot;
    end
  end

  assign pending_empty_next = ~|(cap_pend_next | quiet_pend_next);

  // Pending masks: split on the captured-piece field at load time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_pend_reg   <= '0;
      quiet_pend_reg <= '0;
    end else if (abort) begin
      cap_pend_reg   <= '0;
      quiet_pend_reg <= '0;
    end else if (load_en) begin
      cap_pend_reg   <= word_nz & word_cap;
      quiet_pend_reg <= word_nz & ~word_cap;
    end else if (scan_active) begin
      cap_pend_reg   <= cap_pend_next;
      quiet_pend_reg <= quiet_pend_next;
    end
  end
`else
  logic [NUM_DIR-1:0] pend_reg;
  logic [NUM_DIR-1:0] pend_next;
  logic               pend_found;
  logic [IDX_W-1:0]   pend_idx;
  logic [NUM_DIR-1:0] unused_cap;

  find_first #(.N(NUM_DIR)) u_ff_pend (
    .req   (pend_reg),
    .found (pend_found),
    .index (pend_idx)
  );

  // Capture classification only matters for capture-first ordering
  assign unused_cap  = word_cap;
  assign any_pending = pend_found;
  assign sel         = pend_idx;

  // Remove the transferred move from the pending mask
  always_comb begin
    pend_next = pend_reg;
    if (xfer) pend_next = pend_reg & ~sel_onehot;
  end

  assign pending_empty_next = ~|pend_next;

  // Pending mask: one bit per non-empty word, strict ascending order
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_reg <= '0;
    end else if (abort) begin
      pend_reg <= '0;
    end else if (load_en) begin
      pend_reg <= word_nz;
    end else if (scan_active) begin
      pend_reg <= pend_next;
    end
  end
`endif

  // Move buffer: captured once per start, held for the whole scan
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIR; i++) buffer_reg[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < NUM_DIR; i++) buffer_reg[i] <= moves_in[i*MOVE_W +: MOVE_W];
    end
  end

  // Control: state, done pulse and transfer counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        state_reg <= ST_IDLE;
      end else if (load_en) begin
        state_reg <= ST_SCAN;
        count_reg <= '0;
      end else if (scan_active) begin
        if (xfer && (count_reg != CNT_W'(NUM_DIR))) count_reg <= count_reg + 1'b1;
        // Covers both the last transfer and an empty load
        if (pending_empty_next) begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b1;
        end
      end
    end
  end

  assign out_if.out_valid = scan_active && any_pending;
  assign out_if.out_move  = out_if.out_valid ? buffer_reg[sel] : MOVE_W'(EMPTY_MOVE_OUT);
  assign out_if.out_idx   = out_if.out_valid ? sel : '0;
  assign busy             = scan_active;
  assign done             = done_reg;
  assign move_count       = count_reg;

endmodule

// File: tb/tb_square_move_serializer.sv
// Directed testbench for square_move_serializer (NUM_DIR=16, MOVE_W=32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_square_move_serializer;

  localparam int MOVE_W  = 32;
  localparam int NUM_DIR = 16;

  logic                      clk;
  logic                      reset_n;
  logic                      start;
  logic                      abort;
  logic [NUM_DIR*MOVE_W-1:0] moves_in;
  logic                      busy;
  logic                      done;
  logic [4:0]                move_count;

  int tests_run;
  int tests_failed;

  square_move_serializer_if #(.MOVE_W(MOVE_W), .NUM_DIR(NUM_DIR)) sif ();

  square_move_serializer #(
    .MOVE_W (MOVE_W),
    .NUM_DIR(NUM_DIR),
    .CAP_LSB(18),
    .CAP_W  (6)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .moves_in  (moves_in),
    .out_if    (sif),
    .busy      (busy),
    .done      (done),
    .move_count(move_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quiet move: from-square field only, captured field zero
  function automatic logic [31:0] quiet_word(input int i);
    return 32'h0000_1000 | 32'(i);
  endfunction

  // Capture move: captured-piece field = 6'h21
  function automatic logic [31:0] cap_word(input int i);
    return 32'h0084_0000 | 32'(i);
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [NUM_DIR*MOVE_W-1:0] m);
    moves_in = m;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; moves_in = '0; sif.out_ready = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    tests_run++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, required 0 0 0", sif.out_valid, busy, done);
    end
    tests_run++;
    if (sif.out_move !== 32'h0 || sif.out_idx !== 4'd0 || move_count !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_data: move=%h idx=%0d count=%0d, required 0 0 0", sif.out_move, sif.out_idx, move_count);
    end
  endtask

  task automatic test_stream();
    logic [NUM_DIR*MOVE_W-1:0] m;
    int exp_idx [3];
    exp_idx = '{2, 5, 11};
    m = '0;
    foreach (exp_idx[k]) m[exp_idx[k]*MOVE_W +: MOVE_W] = quiet_word(exp_idx[k]);
    sif.out_ready = 1'b1;
    load(m);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 4'(exp_idx[k]) || sif.out_move !== quiet_word(exp_idx[k])) begin
        tests_failed++;
        $display("FAIL stream_%0d: valid=%b idx=%0d move=%h, required 1 %0d %h",
                 k, sif.out_valid, sif.out_idx, sif.out_move, exp_idx[k], quiet_word(exp_idx[k]));
      end
      cyc();
    end
    tests_run++;
    if (done !== 1'b1 || move_count !== 5'd3 || sif.out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_done: done=%b count=%0d valid=%b busy=%b, required 1 3 0 0", done, move_count, sif.out_valid, busy);
    end
    cyc();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_done_pulse: done=%b, required 0", done);
    end
  endtask

  task automatic test_empty_load();
    sif.out_ready = 1'b1;
    load('0);
    tests_run++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_scan: valid=%b busy=%b done=%b, required 0 1 0", sif.out_valid, busy, done);
    end
    cyc();
    tests_run++;
    if (sif.out_valid !== 1'b0 || done !== 1'b1 || move_count !== 5'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_done: valid=%b done=%b count=%0d busy=%b, required 0 1 0 0", sif.out_valid, done, move_count, busy);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [NUM_DIR*MOVE_W-1:0] m;
    m = '0;
    m[2*MOVE_W +: MOVE_W]  = quiet_word(2);
    m[5*MOVE_W +: MOVE_W]  = quiet_word(5);
    m[11*MOVE_W +: MOVE_W] = quiet_word(11);
    sif.out_ready = 1'b0;
    load(m);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 4'd2 || sif.out_move !== quiet_word(2) || move_count !== 5'd0) begin
        tests_failed++;
        $display("FAIL stall_%0d: valid=%b idx=%0d move=%h count=%0d, required 1 2 %h 0",
                 k, sif.out_valid, sif.out_idx, sif.out_move, move_count, quiet_word(2));
      end
      cyc();
    end
    sif.out_ready = 1'b1;
    cyc();
    tests_run++;
    if (sif.out_idx !== 4'd5 || move_count !== 5'd1) begin
      tests_failed++;
      $display("FAIL stall_release: idx=%0d count=%0d, required 5 1", sif.out_idx, move_count);
    end
    cyc(); cyc();
    tests_run++;
    if (done !== 1'b1 || move_count !== 5'd3) begin
      tests_failed++;
      $display("FAIL stall_done: done=%b count=%0d, required 1 3", done, move_count);
    end
    cyc();
  endtask

  task automatic test_abort();
    logic [NUM_DIR*MOVE_W-1:0] m;
    logic [NUM_DIR*MOVE_W-1:0] other;
    m = '0;
    for (int k = 0; k < 4; k++) m[(k*4)*MOVE_W +: MOVE_W] = quiet_word(k*4);
    other = '0;
    other[15*MOVE_W +: MOVE_W] = quiet_word(15);
    sif.out_ready = 1'b1;
    load(m);
    tests_run++;
    if (sif.out_idx !== 4'd0 || sif.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_first: valid=%b idx=%0d, required 1 0", sif.out_valid, sif.out_idx);
    end
    cyc();
    sif.out_ready = 1'b0;
    // start while busy must be ignored
    moves_in = other;
    start = 1'b1;
    cyc();
    start = 1'b0;
    tests_run++;
    if (sif.out_idx !== 4'd4 || sif.out_move !== quiet_word(4) || move_count !== 5'd1) begin
      tests_failed++;
      $display("FAIL busy_start: idx=%0d move=%h count=%0d, required 4 %h 1", sif.out_idx, sif.out_move, move_count, quiet_word(4));
    end
    abort = 1'b1;
    sif.out_ready = 1'b1;
    cyc();
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || sif.out_valid !== 1'b0 || move_count !== 5'd1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort: busy=%b valid=%b count=%0d done=%b, required 0 0 1 0", busy, sif.out_valid, move_count, done);
    end
    cyc();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [NUM_DIR*MOVE_W-1:0] m;
    int done_seen;
    m = '0;
    m[2*MOVE_W +: MOVE_W]  = quiet_word(2);
    m[5*MOVE_W +: MOVE_W]  = quiet_word(5);
    m[11*MOVE_W +: MOVE_W] = quiet_word(11);
    sif.out_ready = 1'b0;
    load(m);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (sif.out_valid !== 1'b0 || sif.out_move !== 32'h0 || sif.out_idx !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0 || move_count !== 5'd0) begin
      tests_failed++;
      $display("FAIL midscan_reset: valid=%b move=%h idx=%0d busy=%b done=%b count=%0d, required all 0",
               sif.out_valid, sif.out_move, sif.out_idx, busy, done, move_count);
    end
    cyc();
    reset_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (done === 1'b1) done_seen++;
      cyc();
    end
    tests_run++;
    if (done_seen != 0) begin
      tests_failed++;
      $display("FAIL midscan_no_done: done pulses=%0d, required 0", done_seen);
    end
    m = '0;
    m[7*MOVE_W +: MOVE_W] = quiet_word(7);
    sif.out_ready = 1'b1;
    load(m);
    tests_run++;
    if (sif.out_valid !== 1'b1 || sif.out_idx !== 4'd7 || sif.out_move !== quiet_word(7)) begin
      tests_failed++;
      $display("FAIL midscan_restart: valid=%b idx=%0d move=%h, required 1 7 %h", sif.out_valid, sif.out_idx, sif.out_move, quiet_word(7));
    end
    cyc();
    tests_run++;
    if (done !== 1'b1 || move_count !== 5'd1) begin
      tests_failed++;
      $display("FAIL midscan_restart_done: done=%b count=%0d, required 1 1", done, move_count);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [NUM_DIR*MOVE_W-1:0] m;
    logic [NUM_DIR*MOVE_W-1:0] nxt;
    m = '0;
    m[3*MOVE_W +: MOVE_W] = quiet_word(3);
    m[6*MOVE_W +: MOVE_W] = quiet_word(6);
    nxt = '0;
    nxt[1*MOVE_W +: MOVE_W] = quiet_word(1);
    sif.out_ready = 1'b1;
    load(m);
    cyc();
    // start arrives on the same edge as the last transfer: still SCAN, so ignored
    moves_in = nxt;
    start = 1'b1;
    tests_run++;
    if (sif.out_idx !== 4'd6) begin
      tests_failed++;
      $display("FAIL b2b_second: idx=%0d, required 6", sif.out_idx);
    end
    cyc();
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || move_count !== 5'd2) begin
      tests_failed++;
      $display("FAIL b2b_done: done=%b busy=%b count=%0d, required 1 0 2", done, busy, move_count);
    end
    // start held through the done cycle is accepted now that state is IDLE
    cyc();
    start = 1'b0;
    tests_run++;
    if (sif.out_valid !== 1'b1 || sif.out_idx !== 4'd1 || move_count !== 5'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_restart: valid=%b idx=%0d count=%0d done=%b, required 1 1 0 0", sif.out_valid, sif.out_idx, move_count, done);
    end
    cyc();
    tests_run++;
    if (done !== 1'b1 || move_count !== 5'd1) begin
      tests_failed++;
      $display("FAIL b2b_restart_done: done=%b count=%0d, required 1 1", done, move_count);
    end
    cyc();
  endtask

  task automatic test_capture_order();
    logic [NUM_DIR*MOVE_W-1:0] m;
    int exp_idx [3];
    logic [31:0] exp_move [3];
`ifdef CAPTURE_FIRST_EN
    exp_idx = '{3, 9, 1};
    exp_move = '{cap_word(3), cap_word(9), quiet_word(1)};
`else
    exp_idx = '{1, 3, 9};
    exp_move = '{quiet_word(1), cap_word(3), cap_word(9)};
`endif
    m = '0;
    m[1*MOVE_W +: MOVE_W] = quiet_word(1);
    m[9*MOVE_W +: MOVE_W] = cap_word(9);
    m[3*MOVE_W +: MOVE_W] = cap_word(3);
    sif.out_ready = 1'b1;
    load(m);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 4'(exp_idx[k]) || sif.out_move !== exp_move[k]) begin
        tests_failed++;
        $display("FAIL order_%0d: valid=%b idx=%0d move=%h, required 1 %0d %h",
                 k, sif.out_valid, sif.out_idx, sif.out_move, exp_idx[k], exp_move[k]);
      end
      cyc();
    end
    tests_run++;
    if (done !== 1'b1 || move_count !== 5'd3) begin
      tests_failed++;
      $display("FAIL order_done: done=%b count=%0d, required 1 3", done, move_count);
    end
    cyc();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_stream();
    test_empty_load();
    test_backpressure();
    test_abort();
    test_reset_mid_scan();
    test_back_to_back();
    test_capture_order();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
